// File: rtl/osc_clkgen_pkg.sv
// Shared types and sizing helpers for the multi-channel clock generator.
package osc_clkgen_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_RUN      = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

    // Settle counter must hold values up to SETTLE_CYC.
    function automatic int settle_cnt_w(input int settle_cyc);
        return (settle_cyc < 1) ? 1 : $clog2(settle_cyc + 1);
    endfunction

endpackage

// File: rtl/osc_clkgen_chan.sv
// One clock-generator channel: start-up settle, 50% duty square wave,
// and a stop path that always finishes the current high phase.
module osc_clkgen_chan
    import osc_clkgen_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int SETTLE_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [DIV_W-1:0] half_period,
    output logic             dout,
    output logic             ready
);

    localparam int               SW          = settle_cnt_w(SETTLE_CYC);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
    localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);

    state_t           state;
    logic [SW-1:0]    settle_cnt;
    logic [DIV_W-1:0] phase_cnt;
    logic [DIV_W-1:0] hp_eff;
    logic [DIV_W-1:0] hp_in;
    logic             phase_done;

    // A zero half-period would never terminate a phase; treat it as one cycle.
    assign hp_in      = (half_period == '0) ? ONE : half_period;
    assign phase_done = (phase_cnt == hp_eff - ONE);

    // NOTE: every register here, hp_eff included, is reset so a mid-run reset
    // leaves no stale phase; all updates are non-blocking so each branch sees
    // pre-edge values of dout and the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            dout       <= 1'b0;
            ready      <= 1'b0;
            settle_cnt <= '0;
            phase_cnt  <= '0;
            hp_eff     <= '0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (ena) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end

                ST_SETTLE: begin
                    if (!ena) begin
                        state      <= ST_OFF;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= ST_RUN;
                        ready      <= 1'b1;
                        dout       <= 1'b0;
                        phase_cnt  <= '0;
                        hp_eff     <= hp_in;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_ONE;
                    end
                end

                ST_RUN: begin
                    if (phase_done) begin
                        dout      <= ~dout;
                        phase_cnt <= '0;
                        hp_eff    <= hp_in;
                        if (!ena) begin
                            // Toggle wins; a freshly started high phase must still complete.
                            ready <= 1'b0;
                            state <= dout ? ST_OFF : ST_STOPPING;
                        end
                    end else if (!ena && !dout) begin
                        state     <= ST_OFF;
                        ready     <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + ONE;
                        if (!ena) begin
                            state <= ST_STOPPING;
                            ready <= 1'b0;
                        end
                    end
                end

                ST_STOPPING: begin
                    if (phase_done) begin
                        dout      <= 1'b0;
                        phase_cnt <= '0;
                        hp_eff    <= hp_in;
                        if (ena) begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= ST_OFF;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + ONE;
                        if (ena) begin
                            state <= ST_RUN;
                            ready <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_OFF;
                    dout  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/osc_clkgen_multi.sv
// NCH independent housekeeping clock channels; this level only slices the
// half-period bus and gathers the per-channel outputs.
module osc_clkgen_multi
    import osc_clkgen_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int DIV_W      = 16,
    parameter int SETTLE_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       ena,
    input  logic [NCH*DIV_W-1:0] half_period,
    output logic [NCH-1:0]       dout,
    output logic [NCH-1:0]       ready
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        osc_clkgen_chan #(
            .DIV_W      (DIV_W),
            .SETTLE_CYC (SETTLE_CYC)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .ena         (ena[i]),
            .half_period (half_period[i*DIV_W +: DIV_W]),
            .dout        (dout[i]),
            .ready       (ready[i])
        );
    end

endmodule

// File: tb/tb_osc_clkgen_multi.sv
// Self-checking bench: per-edge expectations are queued as stimulus is driven
// and compared on the following falling clock edge.
module tb_osc_clkgen_multi;

    localparam int NCH        = 2;
    localparam int DIV_W      = 16;
    localparam int SETTLE_CYC = 64;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       ena;
    logic [NCH*DIV_W-1:0] half_period;
    logic [NCH-1:0]       dout;
    logic [NCH-1:0]       ready;

    osc_clkgen_multi #(
        .NCH        (NCH),
        .DIV_W      (DIV_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .half_period (half_period),
        .dout        (dout),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] dout;
        logic [NCH-1:0] ready;
        string          tag;
    } exp_t;

    typedef struct {
        int               ch;
        logic [DIV_W-1:0] hp;
        int               hp_eff;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [NCH-1:0] ad, input logic [NCH-1:0] ar,
                         input logic [NCH-1:0] ed, input logic [NCH-1:0] er);
        n_checks++;
        if (ad !== ed || ar !== er) begin
            n_errors++;
            $display("FAIL %s @edge %0d: dout=%b ready=%b, expected dout=%b ready=%b",
                     name, edge_cnt, ad, ar, ed, er);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
            e = sb.pop_front();
            check(e.tag, dout, ready, e.dout, e.ready);
        end
    end

    // Queue the expected outputs after the next rising edge, then step past it.
    task automatic cyc_exp(input int ch, input logic d, input logic r, input string tag);
        exp_t e;
        e.cyc       = edge_cnt + 1;
        e.dout      = '0;
        e.ready     = '0;
        e.dout[ch]  = d;
        e.ready[ch] = r;
        e.tag       = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int ch, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc_exp(ch, 1'b0, 1'b0, tag);
    endtask

    // Edge j after RUN entry: dout is high when floor(j/hp) is odd.
    task automatic run_wave(input int ch, input int hp, input int j0, input int j1,
                            input logic r, input string tag);
        for (int j = j0; j <= j1; j++) cyc_exp(ch, ((j / hp) % 2) == 1, r, tag);
    endtask

    task automatic set_hp(input int ch, input int hp);
        half_period[ch*DIV_W +: DIV_W] = DIV_W'(hp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "bench timeout");
    end

    vec_t vecs[4];

    initial begin
        vecs[0] = '{ch: 0, hp: 16'd5, hp_eff: 5};
        vecs[1] = '{ch: 1, hp: 16'd0, hp_eff: 1};
        vecs[2] = '{ch: 0, hp: 16'd1, hp_eff: 1};
        vecs[3] = '{ch: 1, hp: 16'd3, hp_eff: 3};

        rst_n       = 1'b0;
        ena         = '0;
        half_period = '0;
        #3;
        check("reset_state", dout, ready, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle(0, 2, "post_reset_idle");

        // Table: settle length, first edge, period and stop for several half-periods.
        for (int v = 0; v < 4; v++) begin
            set_hp(vecs[v].ch, int'(vecs[v].hp));
            ena[vecs[v].ch] = 1'b1;
            settle(vecs[v].ch, SETTLE_CYC, "tbl_settle");
            run_wave(vecs[v].ch, vecs[v].hp_eff, 0, 4 * vecs[v].hp_eff, 1'b1, "tbl_run");
            ena[vecs[v].ch] = 1'b0;
            if (vecs[v].hp_eff == 1) begin
                cyc_exp(vecs[v].ch, 1'b1, 1'b0, "tbl_stop_tc_high");
                cyc_exp(vecs[v].ch, 1'b0, 1'b0, "tbl_stop_tc_off");
            end else begin
                cyc_exp(vecs[v].ch, 1'b0, 1'b0, "tbl_stop_low");
            end
            settle(vecs[v].ch, 2, "tbl_idle");
        end

        // Glitch-free stop three cycles into a high phase.
        set_hp(0, 8);
        ena[0] = 1'b1;
        settle(0, SETTLE_CYC, "gf_settle");
        run_wave(0, 8, 0, 10, 1'b1, "gf_run");
        ena[0] = 1'b0;
        run_wave(0, 8, 11, 16, 1'b0, "gf_stopping");
        settle(0, 2, "gf_off");

        // Re-enable while stopping: period continues, no settle repeated.
        ena[0] = 1'b1;
        settle(0, SETTLE_CYC, "re_settle");
        run_wave(0, 8, 0, 10, 1'b1, "re_run");
        ena[0] = 1'b0;
        run_wave(0, 8, 11, 12, 1'b0, "re_stopping");
        ena[0] = 1'b1;
        run_wave(0, 8, 13, 48, 1'b1, "re_resumed");
        ena[0] = 1'b0;
        settle(0, 2, "re_off");

        // Abort settle at count 30, then a full settle is needed again.
        set_hp(0, 5);
        ena[0] = 1'b1;
        settle(0, 31, "abort_settle");
        ena[0] = 1'b0;
        cyc_exp(0, 1'b0, 1'b0, "abort_off");
        ena[0] = 1'b1;
        settle(0, SETTLE_CYC, "abort_full_settle");
        run_wave(0, 5, 0, 7, 1'b1, "abort_run");

        // Asynchronous reset between clock edges while dout is high.
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        ena[0] = 1'b0;
        #1;
        check("async_reset_immediate", dout, ready, '0, '0);
        @(posedge clk);
        #1;
        cyc_exp(0, 1'b0, 1'b0, "in_reset");
        rst_n = 1'b1;
        settle(0, 2, "after_reset");

        // Live half-period change 4 -> 10 during a low phase on channel 1.
        set_hp(1, 4);
        ena[1] = 1'b1;
        settle(1, SETTLE_CYC, "live_settle");
        run_wave(1, 4, 0, 9, 1'b1, "live_hp4");
        set_hp(1, 10);
        for (int j = 10; j <= 11; j++) cyc_exp(1, 1'b0, 1'b1, "live_cur_phase");
        for (int j = 12; j <= 21; j++) cyc_exp(1, 1'b1, 1'b1, "live_hp10_high");
        for (int j = 22; j <= 31; j++) cyc_exp(1, 1'b0, 1'b1, "live_hp10_low");
        // ena falls exactly at a terminal count of a low phase: fresh high phase, then off.
        ena[1] = 1'b0;
        for (int j = 32; j <= 41; j++) cyc_exp(1, 1'b1, 1'b0, "tc_fall_high");
        cyc_exp(1, 1'b0, 1'b0, "tc_fall_off");
        settle(1, 2, "final_idle");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/osc_clkgen_multi.md
Name: osc_clkgen_multi

Overview:
Parametrised multi-channel clock generator, the synthesizable digital successor to the single-output RC oscillator behavioural model. Each of NCH channels derives a square wave from the system clock. Each channel has:
- an enable input
- a programmable half-period
- a start-up settle interval modelling oscillator start-up
- glitch-free stop, so an output never emits a runt high pulse
- a per-channel ready flag

Instances sit in the analog-IP wrapper area, feeding slow housekeeping clocks to always-on logic.

Parameters:
NCH, 2, number of independent output channels (>=1)
DIV_W, 16, width of each half-period field
SETTLE_CYC, 64, clk cycles from enable to RUN (>=1); settle counter width = $clog2(SETTLE_CYC+1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  NCH  per-channel enable, synchronous to clk
half_period  input  NCH*DIV_W  per-channel half-period in clk cycles; channel i uses bits [i*DIV_W +: DIV_W]
dout  output  NCH  generated clock per channel, driven from a flop
ready  output  NCH  per-channel: 1 while the channel is in RUN

Behaviour:
- Channels are fully independent; the description below is per channel.
- Reset (async, rst_n=0):
  - state=OFF, dout=0, ready=0, all counters 0.
  - Reset mid-operation forces this immediately, with no completion of the current phase.
- Effective half-period: hp_eff = (half_period==0) ? 1 : half_period.
  - hp_eff is captured at RUN entry and at every dout toggle.
  - Changes between toggles never shorten or stretch the current phase.
  - Output period = 2*hp_eff cycles; duty cycle is exactly 50%.
- States:
  - OFF: dout=0, ready=0. ena=1 sampled at edge k -> SETTLE, settle counter cleared.
  - SETTLE:
    - dout=0, ready=0; settle counter increments each cycle.
    - ena=0 -> OFF next edge; counter discarded, so a later enable restarts the full settle.
    - When the counter reaches SETTLE_CYC-1 -> RUN at edge k+SETTLE_CYC.
    - ready=1 from that edge; phase counter=0; dout=0.
  - RUN:
    - Phase counter increments each cycle.
    - At count hp_eff-1: dout toggles, counter clears, hp_eff recaptured.
    - First rising dout edge is at edge k+SETTLE_CYC+hp_eff.
    - ena=0 while dout=0 -> OFF next edge, ready=0.
    - ena=0 while dout=1 -> STOPPING next edge, ready=0.
  - STOPPING:
    - High phase continues counting normally.
    - At terminal count dout->0 and state->OFF.
    - ena=1 seen before terminal count -> RUN: ready=1 next edge, counting continues uninterrupted, so there is no phase discontinuity.
- Simultaneous events:
  - Terminal count coincides with ena falling in RUN: the toggle occurs.
    - If the new dout=0, go to OFF.
    - If the new dout=1, go to STOPPING with a fresh high phase.
  - ena toggles 1->0->1 within one cycle are not visible (sampled input only).
- No combinational path from any input to dout or ready.

Decomposition:
- Package osc_clkgen_pkg:
  - state enum (OFF, SETTLE, RUN, STOPPING), 2 bits
  - localparam helper for settle counter width
- Sub-module osc_clkgen_chan:
  - one channel (FSM, settle counter, phase counter, hp_eff register)
  - instantiated NCH times by a generate loop in osc_clkgen_multi, which only slices half_period and concatenates outputs

Test Plan:
1. Reset/start: NCH=2, SETTLE_CYC=64, half_period0=5. rst_n low, then high; ena[0]=1 at edge 0 -> ready[0]=1 at edge 64; dout[0] rises at edge 69, falls 74, period 10. Channel 1 stays 0.
2. Zero half-period: half_period1=0, ena[1]=1 -> after settle, dout[1] toggles every cycle (period 2).
3. Glitch-free stop: hp=8, drop ena 3 cycles into a high phase -> ready falls next edge; dout stays high 5 more cycles, then 0; state OFF, no high pulse shorter than 8.
4. Re-enable in STOPPING: as scenario 3 but reassert ena after 2 cycles -> ready=1 again, dout keeps exact period 16, no settle repeated.
5. Abort settle and async reset: ena dropped at settle count 30 -> OFF; re-enable requires the full 64 cycles. Assert rst_n low mid-RUN between clock edges -> dout and ready are 0 immediately, before the next clk edge.
6. Live period change: hp changed 4->10 mid-low-phase -> current phase stays 4 cycles; the following phase is 10.
